// File: rtl/hazard_ctrl.sv
// Hazard/stall scheduler beside the IF/ID register: load-use stalls, branch-wait
// bubbles, halt drain, and a saturating count of PC-hold cycles.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsc,
  input  logic [4:0]       rtc,
  input  logic             uses_rt,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             br_in_if,
  input  logic             br_resolved,
  input  logic             br_taken,
  input  logic             halt_in,
  output logic             reg_detect_confict,
  output logic             pc_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       state
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_STALL = 3'd1,
    BR_WAIT  = 3'd2,
    DRAIN    = 3'd3,
    HALTED   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  logic load_use;
  logic conflict_c, pc_hold_c, flush_c, bubble_c;

  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == rsc) || (uses_rt && (id_ex_rd == rtc)));

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    halted_d   = halted_q;
    conflict_c = 1'b0;
    pc_hold_c  = 1'b0;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use) begin
          conflict_c = 1'b1;
          pc_hold_c  = 1'b1;
          bubble_c   = 1'b1;
          state_d    = LD_STALL;
        end else if (halt_in) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYC - 1);
        end else if (br_in_if) begin
          state_d = BR_WAIT;
        end
      end
      // ID/EX already carries the bubble, so a lingering load_use match is stale
      LD_STALL: begin
        state_d = RUN;
        if (halt_in) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYC - 1);
        end else if (br_in_if) begin
          state_d = BR_WAIT;
        end
      end
      // hold releases in the resolve cycle so the PC takes EX's redirect at its end
      BR_WAIT: begin
        pc_hold_c = !br_resolved;
        flush_c   = !br_resolved;
        if (br_resolved) state_d = RUN;
      end
      DRAIN: begin
        pc_hold_c = 1'b1;
        flush_c   = 1'b1;
        if (drain_q == '0) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      HALTED: begin
        pc_hold_c = 1'b1;
        flush_c   = 1'b1;
        halted_d  = 1'b1;
      end
      default: begin
        state_d  = RUN;
        halted_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_hold_c && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RUN;
      drain_q  <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    reg_detect_confict = reset && conflict_c;
    pc_hold            = reset && pc_hold_c;
    if_id_flush        = reset && flush_c;
    id_ex_bubble       = reset && bubble_c;
    halted             = reset && halted_q;
    stall_cnt          = reset ? cnt_q : '0;
    state              = reset ? state_q : 3'd0;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch wait, halt drain, reset, saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsc, rtc, id_ex_rd;
  logic        uses_rt, id_ex_memread, br_in_if, br_resolved, br_taken, halt_in;
  logic        conflict, pc_hold, flush, bubble, halted;
  logic [15:0] stall_cnt;
  logic [2:0]  state;
  logic        s_conflict, s_pc_hold, s_flush, s_bubble, s_halted;
  logic [3:0]  s_stall_cnt;
  logic [2:0]  s_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .rsc(rsc), .rtc(rtc), .uses_rt(uses_rt),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .br_in_if(br_in_if),
    .br_resolved(br_resolved), .br_taken(br_taken), .halt_in(halt_in),
    .reg_detect_confict(conflict), .pc_hold(pc_hold), .if_id_flush(flush),
    .id_ex_bubble(bubble), .halted(halted), .stall_cnt(stall_cnt), .state(state)
  );

  hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rsc(rsc), .rtc(rtc), .uses_rt(uses_rt),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .br_in_if(br_in_if),
    .br_resolved(br_resolved), .br_taken(br_taken), .halt_in(halt_in),
    .reg_detect_confict(s_conflict), .pc_hold(s_pc_hold), .if_id_flush(s_flush),
    .id_ex_bubble(s_bubble), .halted(s_halted), .stall_cnt(s_stall_cnt), .state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc;
    @(negedge clk);
  endtask

  task automatic clr;
    rsc = 5'd0; rtc = 5'd0; id_ex_rd = 5'd0; uses_rt = 1'b0; id_ex_memread = 1'b0;
    br_in_if = 1'b0; br_resolved = 1'b0; br_taken = 1'b0; halt_in = 1'b0;
  endtask

  task automatic lu8;
    id_ex_memread = 1'b1; id_ex_rd = 5'd8; rsc = 5'd8;
  endtask

  initial begin
    reset = 1'b0;
    clr();
    nc(); #1;
    chk("rst_state", state, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc_hold", pc_hold, 0);
    nc(); reset = 1'b1; #1;
    chk("idle_pc_hold", pc_hold, 0);
    chk("idle_flush", flush, 0);
    chk("idle_state", state, 0);

    // load-use on rs
    nc(); lu8(); #1;
    chk("lu_conflict", conflict, 1);
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_bubble", bubble, 1);
    chk("lu_flush", flush, 0);
    nc(); #1;
    chk("lds_state", state, 1);
    chk("lds_conflict", conflict, 0);
    chk("lds_pc_hold", pc_hold, 0);
    chk("lds_bubble", bubble, 0);
    chk("lds_cnt", stall_cnt, 1);
    nc(); clr(); #1;
    chk("lu_back_run", state, 0);
    chk("lu_cnt_hold", stall_cnt, 1);

    // rd=0 never stalls
    nc(); id_ex_memread = 1'b1; #1;
    chk("rd0_conflict", conflict, 0);
    chk("rd0_pc_hold", pc_hold, 0);
    // rt match only counts when uses_rt
    nc(); id_ex_rd = 5'd8; rsc = 5'd3; rtc = 5'd8; uses_rt = 1'b0; #1;
    chk("rt_nouse_conflict", conflict, 0);
    uses_rt = 1'b1; #1;
    chk("rt_use_conflict", conflict, 1);
    nc(); clr(); #1;
    chk("rt_lds_state", state, 1);
    chk("rt_cnt", stall_cnt, 2);
    nc(); #1;
    chk("rt_run", state, 0);

    // branch: br_in_if at "cycle 10", resolve at "cycle 13"
    nc(); br_in_if = 1'b1; #1;
    chk("br_c10_pc_hold", pc_hold, 0);
    nc(); br_in_if = 1'b0; #1;
    chk("br_c11_state", state, 2);
    chk("br_c11_pc_hold", pc_hold, 1);
    chk("br_c11_flush", flush, 1);
    chk("br_c11_conflict", conflict, 0);
    nc(); lu8(); halt_in = 1'b1; #1;
    chk("br_c12_pc_hold", pc_hold, 1);
    chk("br_c12_ignore_lu", conflict, 0);
    chk("br_c12_bubble", bubble, 0);
    nc(); clr(); br_resolved = 1'b1; br_taken = 1'b1; #1;
    chk("br_c13_pc_hold", pc_hold, 0);
    chk("br_c13_flush", flush, 0);
    nc(); clr(); #1;
    chk("br_back_run", state, 0);
    chk("br_cnt", stall_cnt, 4);
    nc(); br_resolved = 1'b1; #1;
    chk("stray_res_pc_hold", pc_hold, 0);
    nc(); clr(); #1;
    chk("stray_res_state", state, 0);

    // load-use with br_in_if: stall, LD_STALL, then BR_WAIT
    nc(); lu8(); br_in_if = 1'b1; #1;
    chk("lubr_conflict", conflict, 1);
    chk("lubr_state", state, 0);
    nc(); id_ex_memread = 1'b0; #1;
    chk("lubr_lds", state, 1);
    chk("lubr_lds_pc_hold", pc_hold, 0);
    chk("lubr_cnt", stall_cnt, 5);
    nc(); clr(); #1;
    chk("lubr_brwait", state, 2);
    chk("lubr_brwait_hold", pc_hold, 1);
    nc(); br_resolved = 1'b1; #1;
    chk("lubr_res_hold", pc_hold, 0);
    nc(); clr(); #1;
    chk("lubr_run", state, 0);
    chk("lubr_cnt2", stall_cnt, 6);

    // load-use with halt_in: stall first, DRAIN one cycle later
    nc(); lu8(); halt_in = 1'b1; #1;
    chk("luh_conflict", conflict, 1);
    nc(); id_ex_memread = 1'b0; #1;
    chk("luh_lds", state, 1);
    nc(); clr(); #1;
    chk("luh_drain", state, 3);
    chk("luh_pc_hold", pc_hold, 1);
    chk("luh_flush", flush, 1);
    chk("luh_halted", halted, 0);

    // reset one cycle into DRAIN
    nc(); reset = 1'b0; #1;
    chk("rstd_pc_hold", pc_hold, 0);
    chk("rstd_flush", flush, 0);
    chk("rstd_state", state, 0);
    nc(); reset = 1'b1; #1;
    chk("rstd_after_state", state, 0);
    chk("rstd_after_cnt", stall_cnt, 0);
    chk("rstd_after_pc_hold", pc_hold, 0);
    chk("rstd_after_halted", halted, 0);
    chk("rstd_sat_cnt", s_stall_cnt, 0);
    nc(); #1;
    chk("rstd_stays_run", state, 0);

    // halt at "cycle 5": hold from 6, halted from 9
    nc(); halt_in = 1'b1; #1;
    chk("h5_pc_hold", pc_hold, 0);
    nc(); clr(); #1;
    chk("h6_state", state, 3);
    chk("h6_pc_hold", pc_hold, 1);
    chk("h6_halted", halted, 0);
    nc(); #1;
    chk("h7_halted", halted, 0);
    nc(); #1;
    chk("h8_halted", halted, 0);
    chk("h8_state", state, 3);
    nc(); lu8(); br_in_if = 1'b1; #1;
    chk("h9_halted", halted, 1);
    chk("h9_state", state, 4);
    chk("h9_conflict", conflict, 0);
    chk("h9_bubble", bubble, 0);
    chk("h9_pc_hold", pc_hold, 1);
    nc(); clr(); #1;
    chk("h10_state", state, 4);
    chk("h10_halted", halted, 1);
    chk("h10_cnt", stall_cnt, 4);

    repeat (20) nc();
    #1;
    chk("sat_cnt", s_stall_cnt, 15);
    chk("wide_cnt", stall_cnt, 24);
    chk("sat_halted", s_halted, 1);
    nc(); #1;
    chk("sat_cnt_holds", s_stall_cnt, 15);
    chk("wide_cnt2", stall_cnt, 25);
    chk("halted_absorb", state, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
